// File: rtl/adder_result_display.sv
// Purpose: captures the 4-bit adder result {carry, sum} and scans it onto a
//          4-digit active-low 7-segment display in decimal (0..31) or hex (00..1F).
// Latency: value one clk after load; an/seg/dp one clk after value or scan_idx change.
// Backpressure: none -- load is a fire-and-forget strobe, display is a pure sink.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-high reset
//   load      capture strobe for {carry, sum}
//   sum       adder sum bits
//   carry     adder carry-out
//   hex_mode  0 = decimal, 1 = hex; used live, not captured
//   value     registered captured result {carry, sum}
//   an        digit enables, active-low, an[0] = rightmost digit
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   dp        decimal point, active-low; lit on digit0 when value[4]=1

module adder_result_display #(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] sum,
  input  logic       carry,
  input  logic       hex_mode,
  output logic [4:0] value,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_TAG_DEC = 7'h21;  // 'd'
  localparam logic [6:0] SEG_TAG_HEX = 7'h0B;  // 'h'

  // Active-low {g,f,e,d,c,b,a} glyphs for one hex digit.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [4:0]       r_value;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_scan_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_tick;
  logic [1:0]       w_tens;
  logic [3:0]       w_units_off;
  logic [3:0]       w_units;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;

  assign w_tick = (r_div == DIV_LAST);

  // Result capture; load held high captures every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= {carry, sum};
    end
  end

  // Scan-rate divider and digit index; scan_idx wraps 3->0 by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_scan_idx <= 2'd0;
    end else begin
      if (w_tick) begin
        r_div      <= '0;
        r_scan_idx <= r_scan_idx + 2'd1;
      end else begin
        r_div      <= r_div + 1'b1;
      end
    end
  end

  // Decimal split by comparison, no divider.
  always_comb begin
    w_tens = 2'd0;
    if (r_value >= 5'd30) begin
      w_tens = 2'd3;
    end else if (r_value >= 5'd20) begin
      w_tens = 2'd2;
    end else if (r_value >= 5'd10) begin
      w_tens = 2'd1;
    end
  end

  // units = value - 10*tens. The result is always < 10, so the subtraction
  // can be done mod 16 on value[3:0]: 10, 20, 30 reduce to 10, 4, 14.
  always_comb begin
    w_units_off = 4'd0;
    case (w_tens)
      2'd1:    w_units_off = 4'd10;
      2'd2:    w_units_off = 4'd4;
      2'd3:    w_units_off = 4'd14;
      default: w_units_off = 4'd0;
    endcase
  end

  assign w_units  = r_value[3:0] - w_units_off;
  assign w_an_nxt = ~(4'b0001 << r_scan_idx);

  // Segment pattern for the currently selected digit.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    case (r_scan_idx)
      2'd0: begin
        w_seg_nxt = hex_mode ? glyph(r_value[3:0]) : glyph(w_units);
        // Overflow beyond 4 bits is flagged by the point on the units digit.
        w_dp_nxt  = ~r_value[4];
      end
      2'd1: begin
        if (hex_mode) begin
          if (r_value[4]) begin
            w_seg_nxt = glyph(4'd1);
          end
        end else if (w_tens != 2'd0) begin
          w_seg_nxt = glyph({2'b00, w_tens});
        end
      end
      2'd2: begin
        w_seg_nxt = SEG_BLANK;
      end
      default: begin
        w_seg_nxt = hex_mode ? SEG_TAG_HEX : SEG_TAG_DEC;
      end
    endcase
  end

  // Registered display outputs; all dark while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign value = r_value;
  assign an    = r_an;
  assign seg   = r_seg;
  assign dp    = r_dp;

endmodule

// File: tb/tb_adder_result_display.sv
// Purpose: directed self-checking bench for adder_result_display (CLK_DIV=4).
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: none; inputs driven with blocking assignments between edges.

module tb_adder_result_display;

  localparam int CLK_DIV = 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       load     = 1'b0;
  logic [3:0] sum      = 4'd0;
  logic       carry    = 1'b0;
  logic       hex_mode = 1'b0;
  logic [4:0] value;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit clk_en = 1'b0;

  adder_result_display #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .sum      (sum),
    .carry    (carry),
    .hex_mode (hex_mode),
    .value    (value),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 if (clk_en) clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Digit shown after edge n: scan index as it stood after edge n-1.
  function automatic int exp_idx(int n);
    return ((n - 1) / CLK_DIV) % 4;
  endfunction

  function automatic logic [3:0] exp_an(int n);
    case (exp_idx(n))
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int n, int v, bit h);
    int i = exp_idx(n);
    if (i == 0) return h ? glyph(v % 16) : glyph(v % 10);
    if (i == 1) begin
      if (h) return (v >= 16) ? glyph(1) : 7'h7F;
      return (v >= 10) ? glyph(v / 10) : 7'h7F;
    end
    if (i == 2) return 7'h7F;
    return h ? 7'h0B : 7'h21;
  endfunction

  function automatic logic exp_dp(int n, int v);
    return (exp_idx(n) == 0 && v >= 16) ? 1'b0 : 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture edge, then one more edge so the display reflects the new value.
  task automatic do_load(input logic [3:0] s, input logic c);
    sum = s; carry = c; load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (value !== 5'd0)     begin n_fail++; $display("FAIL reset_value: got %0d want 0", value); end
    n_cmp++; if (an !== 4'b1111)     begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_cmp++; if (seg !== 7'h7F)      begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
    n_cmp++; if (dp !== 1'b1)        begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
    #2 rst = 1'b0;
    #2 clk_en = 1'b1;
    step();
    n_cmp++; if (an !== 4'b1110)     begin n_fail++; $display("FAIL first_edge_an: got %b want 1110", an); end
    n_cmp++; if (seg !== 7'h40)      begin n_fail++; $display("FAIL first_edge_seg: got %h want 40", seg); end
    n_cmp++; if (dp !== 1'b1)        begin n_fail++; $display("FAIL first_edge_dp: got %b want 1", dp); end
  endtask

  task automatic test_scan_timing();
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++; if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL scan_an cyc=%0d: got %b want %b", cyc, an, exp_an(cyc)); end
      n_cmp++; if (seg !== exp_seg(cyc, 0, 1'b0)) begin n_fail++; $display("FAIL scan_seg cyc=%0d: got %h want %h", cyc, seg, exp_seg(cyc, 0, 1'b0)); end
    end
  endtask

  task automatic test_max_decimal();
    hex_mode = 1'b0;
    do_load(4'hF, 1'b1);
    n_cmp++; if (value !== 5'd31) begin n_fail++; $display("FAIL max_value: got %0d want 31", value); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL max_dec_an cyc=%0d: got %b want %b", cyc, an, exp_an(cyc)); end
      n_cmp++; if (seg !== exp_seg(cyc, 31, 1'b0)) begin n_fail++; $display("FAIL max_dec_seg cyc=%0d: got %h want %h", cyc, seg, exp_seg(cyc, 31, 1'b0)); end
      n_cmp++; if (dp !== exp_dp(cyc, 31)) begin n_fail++; $display("FAIL max_dec_dp cyc=%0d: got %b want %b", cyc, dp, exp_dp(cyc, 31)); end
      step();
    end
  endtask

  task automatic test_hex_mode();
    hex_mode = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (seg !== exp_seg(cyc, 31, 1'b1)) begin n_fail++; $display("FAIL hex31_seg cyc=%0d: got %h want %h", cyc, seg, exp_seg(cyc, 31, 1'b1)); end
      n_cmp++; if (dp !== exp_dp(cyc, 31)) begin n_fail++; $display("FAIL hex31_dp cyc=%0d: got %b want %b", cyc, dp, exp_dp(cyc, 31)); end
      step();
    end
    do_load(4'h5, 1'b0);
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL hex5_an cyc=%0d: got %b want %b", cyc, an, exp_an(cyc)); end
      n_cmp++; if (seg !== exp_seg(cyc, 5, 1'b1)) begin n_fail++; $display("FAIL hex5_seg cyc=%0d: got %h want %h", cyc, seg, exp_seg(cyc, 5, 1'b1)); end
      step();
    end
  endtask

  task automatic test_collision();
    hex_mode = 1'b0;
    for (int k = 0; k < 16 && (cyc % 16) != 3; k++) step();
    n_cmp++; if ((cyc % 16) != 3) begin n_fail++; $display("FAIL collision_align: cyc=%0d want cyc%%16=3", cyc); end
    sum = 4'hA; carry = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++; if (value !== 5'd10) begin n_fail++; $display("FAIL collision_value: got %0d want 10", value); end
    step();
    n_cmp++; if (an !== 4'b1101) begin n_fail++; $display("FAIL collision_an: got %b want 1101", an); end
    n_cmp++; if (seg !== 7'h79)  begin n_fail++; $display("FAIL collision_seg: got %h want 79", seg); end
    n_cmp++; if (dp !== 1'b1)    begin n_fail++; $display("FAIL collision_dp: got %b want 1", dp); end
    for (int k = 0; k < 16 && exp_idx(cyc) != 0; k++) step();
    n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL collision_d0_an: got %b want 1110", an); end
    n_cmp++; if (seg !== 7'h40)  begin n_fail++; $display("FAIL collision_d0_seg: got %h want 40", seg); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] vals [6];
    vals = '{5'h00, 5'h1F, 5'h10, 5'h0F, 5'h15, 5'h0A};
    hex_mode = 1'b0;
    load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      {carry, sum} = vals[k];
      step();
      n_cmp++; if (value !== vals[k]) begin n_fail++; $display("FAIL b2b_value k=%0d: got %h want %h", k, value, vals[k]); end
    end
    load = 1'b0;
    {carry, sum} = 5'h1E;
    step();
    n_cmp++; if (value !== 5'h0A) begin n_fail++; $display("FAIL hold_value: got %h want 0a", value); end
    n_cmp++; if (seg !== exp_seg(cyc, 10, 1'b0)) begin n_fail++; $display("FAIL hold_seg cyc=%0d: got %h want %h", cyc, seg, exp_seg(cyc, 10, 1'b0)); end
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 32; v++) begin
      do_load(4'(v), 1'(v >> 4));
      n_cmp++; if (value !== 5'(v)) begin n_fail++; $display("FAIL sweep_value: got %0d want %0d", value, v); end
      for (int h = 0; h < 2; h++) begin
        hex_mode = 1'(h);
        step();
        for (int k = 0; k < 16; k++) begin
          n_cmp++; if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL sweep_an v=%0d h=%0d: got %b want %b", v, h, an, exp_an(cyc)); end
          n_cmp++; if (seg !== exp_seg(cyc, v, 1'(h))) begin n_fail++; $display("FAIL sweep_seg v=%0d h=%0d cyc=%0d: got %h want %h", v, h, cyc, seg, exp_seg(cyc, v, 1'(h))); end
          n_cmp++; if (dp !== exp_dp(cyc, v)) begin n_fail++; $display("FAIL sweep_dp v=%0d h=%0d cyc=%0d: got %b want %b", v, h, cyc, dp, exp_dp(cyc, v)); end
          step();
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    hex_mode = 1'b0;
    sum = 4'h7; carry = 1'b1; load = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (value !== 5'd0) begin n_fail++; $display("FAIL midrst_value: got %0d want 0", value); end
    n_cmp++; if (an !== 4'b1111) begin n_fail++; $display("FAIL midrst_an: got %b want 1111", an); end
    n_cmp++; if (seg !== 7'h7F)  begin n_fail++; $display("FAIL midrst_seg: got %h want 7f", seg); end
    n_cmp++; if (dp !== 1'b1)    begin n_fail++; $display("FAIL midrst_dp: got %b want 1", dp); end
    #1 rst = 1'b0;
    load = 1'b0;
    step();
    n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL postrst_an: got %b want 1110", an); end
    n_cmp++; if (seg !== 7'h40)  begin n_fail++; $display("FAIL postrst_seg: got %h want 40", seg); end
    n_cmp++; if (value !== 5'd0) begin n_fail++; $display("FAIL postrst_value: got %0d want 0", value); end
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_max_decimal();
    test_hex_mode();
    test_collision();
    test_back_to_back();
    test_exhaustive();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
